// File: rtl/haar_stage_sequencer.sv
// Second-phase Haar cascade sequencer: strobes each stage database, accumulates weak-learner values, thresholds, verdicts.
// Optional ACC watchdog is built only when HAAR_SEQ_TIMEOUT_EN is defined.
module haar_stage_sequencer #(
    parameter int unsigned NUM_STAGES     = 8,
    parameter int unsigned ADDR_WIDTH     = 12,
    parameter int unsigned DATA_WIDTH_16  = 16,
    parameter int unsigned ACC_WIDTH      = 20,
    parameter int unsigned TIMEOUT_CYCLES = 1023
) (
    input  logic                     clk_fpga,
    input  logic                     reset_fpga,
    input  logic                     i_start,
    input  logic                     i_abort,
    input  logic                     i_feature_valid,
    input  logic [DATA_WIDTH_16-1:0] i_feature_value,
    input  logic [NUM_STAGES-1:0]    i_end_count_classifier_index,
    input  logic [DATA_WIDTH_16-1:0] i_stage_threshold,
    output logic [NUM_STAGES-1:0]    o_rden,
    output logic [ADDR_WIDTH-1:0]    o_stage_index,
    output logic [ADDR_WIDTH-1:0]    o_classifier_count,
    output logic                     o_busy,
    output logic                     o_done,
    output logic                     o_face,
    output logic [ADDR_WIDTH-1:0]    o_reject_stage,
    output logic                     o_timeout
);

    localparam int unsigned SEL_W = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;
    localparam logic signed [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
    localparam logic signed [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};

    if (ACC_WIDTH <= DATA_WIDTH_16 || TIMEOUT_CYCLES == 0) begin : g_param_check
        $error("haar_stage_sequencer: ACC_WIDTH must exceed DATA_WIDTH_16 and TIMEOUT_CYCLES must be nonzero");
    end

    typedef enum logic [2:0] {IDLE, REQ, ACC, EVAL, DONE} state_t;

    state_t                      state;
    logic signed [ACC_WIDTH-1:0] acc;

    logic [SEL_W-1:0]            stage_sel_c;
    logic                        end_flag_c;
    logic signed [ACC_WIDTH:0]   sum_c;
    logic signed [ACC_WIDTH-1:0] acc_next_c;
    logic signed [ACC_WIDTH-1:0] thr_ext_c;
    logic                        pass_c;
    logic                        last_stage_c;
    logic [NUM_STAGES-1:0]       next_rden_c;
    logic                        wdog_hit_c;

    // Saturating accumulate, threshold compare and next-stage strobe decode
    always_comb begin
        stage_sel_c  = o_stage_index[SEL_W-1:0];
        end_flag_c   = i_end_count_classifier_index[stage_sel_c];
        sum_c        = {acc[ACC_WIDTH-1], acc}
                     + {{(ACC_WIDTH+1-DATA_WIDTH_16){i_feature_value[DATA_WIDTH_16-1]}}, i_feature_value};
        acc_next_c   = sum_c[ACC_WIDTH-1:0];
        if (sum_c[ACC_WIDTH] != sum_c[ACC_WIDTH-1]) begin
            acc_next_c = sum_c[ACC_WIDTH] ? ACC_MIN : ACC_MAX;
        end
        thr_ext_c    = {{(ACC_WIDTH-DATA_WIDTH_16){i_stage_threshold[DATA_WIDTH_16-1]}}, i_stage_threshold};
        pass_c       = (acc >= thr_ext_c);
        last_stage_c = (o_stage_index == ADDR_WIDTH'(NUM_STAGES - 1));
        next_rden_c  = NUM_STAGES'(1) << (stage_sel_c + SEL_W'(1));
    end

    // Window sequencing; abort outranks every other transition
    always_ff @(posedge clk_fpga or posedge reset_fpga) begin
        if (reset_fpga) begin
            state              <= IDLE;
            acc                <= '0;
            o_rden             <= '0;
            o_stage_index      <= '0;
            o_classifier_count <= '0;
            o_busy             <= 1'b0;
            o_done             <= 1'b0;
            o_face             <= 1'b0;
            o_reject_stage     <= '0;
        end else begin
            o_rden <= '0;
            o_done <= 1'b0;
            if (state != IDLE && i_abort) begin
                state  <= IDLE;
                o_busy <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (i_start) begin
                            acc                <= '0;
                            o_classifier_count <= '0;
                            o_stage_index      <= '0;
                            o_rden             <= NUM_STAGES'(1);
                            o_busy             <= 1'b1;
                            state              <= REQ;
                        end
                    end
                    REQ: state <= ACC;
                    ACC: begin
                        if (i_feature_valid) begin
                            acc <= acc_next_c;
                            if (o_classifier_count != '1) begin
                                o_classifier_count <= o_classifier_count + ADDR_WIDTH'(1);
                            end
                            if (end_flag_c) begin
                                state <= EVAL;
                            end
                        end else if (wdog_hit_c) begin
                            state  <= IDLE;
                            o_busy <= 1'b0;
                        end
                    end
                    EVAL: begin
                        if (!pass_c) begin
                            o_face         <= 1'b0;
                            o_reject_stage <= o_stage_index;
                            o_done         <= 1'b1;
                            state          <= DONE;
                        end else if (last_stage_c) begin
                            o_face         <= 1'b1;
                            o_reject_stage <= ADDR_WIDTH'(NUM_STAGES);
                            o_done         <= 1'b1;
                            state          <= DONE;
                        end else begin
                            o_stage_index      <= o_stage_index + ADDR_WIDTH'(1);
                            acc                <= '0;
                            o_classifier_count <= '0;
                            o_rden             <= next_rden_c;
                            state              <= REQ;
                        end
                    end
                    DONE: begin
                        state  <= IDLE;
                        o_busy <= 1'b0;
                    end
                    default: begin
                        state  <= IDLE;
                        o_busy <= 1'b0;
                    end
                endcase
            end
        end
    end

`ifdef HAAR_SEQ_TIMEOUT_EN
    localparam int unsigned WD_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [WD_W-1:0] wdog;

    assign wdog_hit_c = (wdog == WD_W'(TIMEOUT_CYCLES - 1));

    // Idle-cycle counter in ACC; any valid or leaving ACC restarts it
    always_ff @(posedge clk_fpga or posedge reset_fpga) begin
        if (reset_fpga) begin
            wdog      <= '0;
            o_timeout <= 1'b0;
        end else begin
            wdog      <= (state == ACC && !i_feature_valid) ? wdog + WD_W'(1) : '0;
            o_timeout <= (state == ACC) && !i_abort && !i_feature_valid && wdog_hit_c;
        end
    end
`else
    assign wdog_hit_c = 1'b0;
    assign o_timeout  = 1'b0;
`endif

endmodule

// File: tb/tb_haar_stage_sequencer.sv
// Scoreboard bench for haar_stage_sequencer: strobes and verdicts are queued as expected and popped by a monitor.
module tb_haar_stage_sequencer;

    localparam int unsigned NS   = 8;
    localparam int unsigned AW   = 12;
    localparam int unsigned DW   = 16;
    localparam int unsigned ACCW = 20;
    localparam int unsigned TO   = 16;

    logic          clk_fpga = 1'b0;
    logic          reset_fpga = 1'b0;
    logic          i_start = 1'b0;
    logic          i_abort = 1'b0;
    logic          i_feature_valid = 1'b0;
    logic [DW-1:0] i_feature_value = '0;
    logic [NS-1:0] i_end_count_classifier_index = '0;
    logic [DW-1:0] i_stage_threshold = '0;
    logic [NS-1:0] o_rden;
    logic [AW-1:0] o_stage_index;
    logic [AW-1:0] o_classifier_count;
    logic          o_busy;
    logic          o_done;
    logic          o_face;
    logic [AW-1:0] o_reject_stage;
    logic          o_timeout;

    int checks = 0;
    int failures = 0;

    logic [NS-1:0] exp_rden_q[$];
    logic [AW:0]   exp_verdict_q[$];
    logic [NS-1:0] mon_rden;
    logic [AW:0]   mon_verdict;

    haar_stage_sequencer #(
        .NUM_STAGES(NS), .ADDR_WIDTH(AW), .DATA_WIDTH_16(DW), .ACC_WIDTH(ACCW), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk_fpga(clk_fpga),
        .reset_fpga(reset_fpga),
        .i_start(i_start),
        .i_abort(i_abort),
        .i_feature_valid(i_feature_valid),
        .i_feature_value(i_feature_value),
        .i_end_count_classifier_index(i_end_count_classifier_index),
        .i_stage_threshold(i_stage_threshold),
        .o_rden(o_rden),
        .o_stage_index(o_stage_index),
        .o_classifier_count(o_classifier_count),
        .o_busy(o_busy),
        .o_done(o_done),
        .o_face(o_face),
        .o_reject_stage(o_reject_stage),
        .o_timeout(o_timeout)
    );

    always #5 clk_fpga = ~clk_fpga;

    // Monitor: every strobe and every verdict must match the head of its queue
    always @(negedge clk_fpga) begin
        if (!reset_fpga) begin
            if (o_rden != '0) begin
                checks++;
                if (exp_rden_q.size() == 0) begin
                    failures++;
                    $display("FAIL rden_unexpected got=%b required=none", o_rden);
                end else begin
                    mon_rden = exp_rden_q.pop_front();
                    if (o_rden !== mon_rden) begin
                        failures++;
                        $display("FAIL rden_order got=%b required=%b", o_rden, mon_rden);
                    end
                end
            end
            if (o_done) begin
                checks++;
                if (exp_verdict_q.size() == 0) begin
                    failures++;
                    $display("FAIL done_unexpected face=%0d reject=%0d required=none", o_face, o_reject_stage);
                end else begin
                    mon_verdict = exp_verdict_q.pop_front();
                    if ({o_face, o_reject_stage} !== mon_verdict) begin
                        failures++;
                        $display("FAIL verdict got face=%0d reject=%0d required face=%0d reject=%0d",
                                 o_face, o_reject_stage, mon_verdict[AW], mon_verdict[AW-1:0]);
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL global_time_limit reached got=running required=finished");
        $fatal(1, "time limit");
    end

    task automatic push_strobes(input int first, input int last);
        for (int s = first; s <= last; s++) exp_rden_q.push_back(NS'(1) << s);
    endtask

    task automatic start_window();
        @(negedge clk_fpga);
        i_start = 1'b1;
        @(negedge clk_fpga);
        i_start = 1'b0;
    endtask

    // Bounded wait for the strobe at a negedge; a missing strobe counts as a failed comparison
    task automatic wait_rden();
        for (int i = 0; i < 20; i++) begin
            if (o_rden != '0) break;
            @(negedge clk_fpga);
        end
        checks++;
        if (o_rden === '0) begin
            failures++;
            $display("FAIL wait_rden got=%b required=nonzero", o_rden);
        end
    endtask

    // Feeds one stage; returns at the negedge of the EVAL cycle
    task automatic feed_stage(input int stage, input int n, input int val, input int last_val,
                              input int thr, input bit junk, input bit gap);
        logic [NS-1:0] own;
        own = NS'(1) << stage;
        wait_rden();
        i_start = 1'b0;
        i_stage_threshold = DW'(thr);
        if (junk) begin
            i_feature_valid = 1'b1;
            i_feature_value = DW'(-30000);
            i_end_count_classifier_index = own;
        end
        for (int i = 0; i < n; i++) begin
            @(negedge clk_fpga);
            if (gap && i == 1) begin
                i_feature_valid = 1'b0;
                i_end_count_classifier_index = own;
                @(negedge clk_fpga);
            end
            i_feature_valid = 1'b1;
            i_feature_value = DW'((i == n - 1) ? last_val : val);
            i_end_count_classifier_index = (i == n - 1) ? own : ~own;
        end
        @(negedge clk_fpga);
        i_feature_valid = 1'b0;
        i_end_count_classifier_index = '0;
    endtask

    task automatic test_queues_empty(input string name);
        checks++;
        if (exp_rden_q.size() != 0 || exp_verdict_q.size() != 0) begin
            failures++;
            $display("FAIL %s_queues got rden_left=%0d verdict_left=%0d required=0", name,
                     exp_rden_q.size(), exp_verdict_q.size());
        end
    endtask

    task automatic check_reset_values(input string name);
        checks++;
        if (o_rden !== '0 || o_stage_index !== '0 || o_classifier_count !== '0 || o_busy !== 1'b0 ||
            o_done !== 1'b0 || o_face !== 1'b0 || o_reject_stage !== '0 || o_timeout !== 1'b0) begin
            failures++;
            $display("FAIL %s got rden=%b stage=%0d count=%0d busy=%b done=%b face=%b reject=%0d to=%b required=all zero",
                     name, o_rden, o_stage_index, o_classifier_count, o_busy, o_done, o_face, o_reject_stage, o_timeout);
        end
    endtask

    task automatic test_reset();
        #2 reset_fpga = 1'b1;
        @(negedge clk_fpga);
        @(negedge clk_fpga);
        check_reset_values("reset_initial");
        reset_fpga = 1'b0;
        @(negedge clk_fpga);
        checks++;
        if (o_busy !== 1'b0) begin
            failures++;
            $display("FAIL idle_after_reset got busy=%b required=0", o_busy);
        end
    endtask

    task automatic test_all_pass();
        push_strobes(0, NS - 1);
        exp_verdict_q.push_back({1'b1, AW'(NS)});
        start_window();
        for (int s = 0; s < NS; s++) begin
            feed_stage(s, 4, 10, 10, 40, 1'b0, s == 1);
            checks++;
            if (o_classifier_count !== AW'(4) || o_stage_index !== AW'(s)) begin
                failures++;
                $display("FAIL all_pass_count stage=%0d got count=%0d idx=%0d required count=4 idx=%0d",
                         s, o_classifier_count, o_stage_index, s);
            end
        end
        @(negedge clk_fpga);
        checks++;
        if (o_done !== 1'b1 || o_face !== 1'b1 || o_reject_stage !== AW'(NS)) begin
            failures++;
            $display("FAIL all_pass_verdict got done=%b face=%b reject=%0d required done=1 face=1 reject=%0d",
                     o_done, o_face, o_reject_stage, NS);
        end
        @(negedge clk_fpga);
        test_queues_empty("all_pass");
    endtask

    task automatic test_reset_mid_acc();
        push_strobes(0, 3);
        start_window();
        for (int s = 0; s < 3; s++) feed_stage(s, 4, 10, 10, 40, 1'b0, 1'b0);
        wait_rden();
        for (int i = 0; i < 2; i++) begin
            @(negedge clk_fpga);
            i_feature_valid = 1'b1;
            i_feature_value = DW'(10);
            i_end_count_classifier_index = ~NS'(8);
        end
        @(negedge clk_fpga);
        i_feature_valid = 1'b0;
        i_end_count_classifier_index = '0;
        checks++;
        if (o_classifier_count !== AW'(2) || o_stage_index !== AW'(3) || o_busy !== 1'b1) begin
            failures++;
            $display("FAIL pre_reset got count=%0d idx=%0d busy=%b required count=2 idx=3 busy=1",
                     o_classifier_count, o_stage_index, o_busy);
        end
        #2 reset_fpga = 1'b1;
        #1 check_reset_values("reset_async_mid_acc");
        @(negedge clk_fpga);
        check_reset_values("reset_held");
        reset_fpga = 1'b0;
        test_queues_empty("reset_mid_acc");
        exp_rden_q.push_back(NS'(1));
        start_window();
        wait_rden();
        checks++;
        if (o_rden !== NS'(1)) begin
            failures++;
            $display("FAIL restart_strobe got=%b required=%b", o_rden, NS'(1));
        end
        i_abort = 1'b1;
        @(negedge clk_fpga);
        i_abort = 1'b0;
        checks++;
        if (o_busy !== 1'b0) begin
            failures++;
            $display("FAIL abort_in_req got busy=%b required=0", o_busy);
        end
        test_queues_empty("restart");
    endtask

    task automatic test_saturation();
        push_strobes(0, 2);
        exp_verdict_q.push_back({1'b0, AW'(2)});
        start_window();
        feed_stage(0, 40, 32767, 32767, 32767, 1'b0, 1'b0);
        checks++;
        if (o_classifier_count !== AW'(40)) begin
            failures++;
            $display("FAIL sat_count got=%0d required=40", o_classifier_count);
        end
        feed_stage(1, 17, 32767, 32767, 32767, 1'b0, 1'b0);
        feed_stage(2, 17, -32768, -32768, -32768, 1'b0, 1'b0);
        @(negedge clk_fpga);
        @(negedge clk_fpga);
        test_queues_empty("saturation");
    endtask

    task automatic test_stage_fail();
        push_strobes(0, 2);
        exp_verdict_q.push_back({1'b0, AW'(2)});
        start_window();
        feed_stage(0, 4, 10, 10, 40, 1'b1, 1'b0);
        feed_stage(1, 4, 10, 10, 40, 1'b0, 1'b0);
        feed_stage(2, 4, 10, 9, 40, 1'b0, 1'b0);
        @(negedge clk_fpga);
        checks++;
        if (o_done !== 1'b1 || o_face !== 1'b0 || o_reject_stage !== AW'(2)) begin
            failures++;
            $display("FAIL fail_verdict got done=%b face=%b reject=%0d required done=1 face=0 reject=2",
                     o_done, o_face, o_reject_stage);
        end
        repeat (4) @(negedge clk_fpga);
        test_queues_empty("stage_fail");
    endtask

    task automatic test_back_to_back();
        exp_rden_q.push_back(NS'(1));
        exp_verdict_q.push_back({1'b0, AW'(0)});
        push_strobes(0, NS - 1);
        exp_verdict_q.push_back({1'b1, AW'(NS)});
        start_window();
        feed_stage(0, 1, -5, -5, 0, 1'b0, 1'b0);
        @(negedge clk_fpga);
        i_start = 1'b1;
        checks++;
        if (o_done !== 1'b1) begin
            failures++;
            $display("FAIL b2b_done got=%b required=1", o_done);
        end
        @(negedge clk_fpga);
        checks++;
        if (o_busy !== 1'b0) begin
            failures++;
            $display("FAIL b2b_idle got busy=%b required=0", o_busy);
        end
        @(negedge clk_fpga);
        i_start = 1'b0;
        checks++;
        if (o_rden !== NS'(1)) begin
            failures++;
            $display("FAIL b2b_restart got rden=%b required=%b", o_rden, NS'(1));
        end
        for (int s = 0; s < NS; s++) feed_stage(s, 1, 0, 0, 0, 1'b0, 1'b0);
        @(negedge clk_fpga);
        @(negedge clk_fpga);
        test_queues_empty("back_to_back");
    endtask

    task automatic test_abort_eval();
        push_strobes(0, 5);
        start_window();
        for (int s = 0; s < 5; s++) feed_stage(s, 4, 10, 10, 40, 1'b0, 1'b0);
        i_start = 1'b1;
        feed_stage(5, 4, 10, 10, 40, 1'b0, 1'b0);
        i_abort = 1'b1;
        @(negedge clk_fpga);
        i_abort = 1'b0;
        checks++;
        if (o_busy !== 1'b0 || o_done !== 1'b0 || o_face !== 1'b1 || o_reject_stage !== AW'(NS)) begin
            failures++;
            $display("FAIL abort_eval got busy=%b done=%b face=%b reject=%0d required busy=0 done=0 face=1 reject=%0d",
                     o_busy, o_done, o_face, o_reject_stage, NS);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_fpga);
            checks++;
            if (o_busy !== 1'b0) begin
                failures++;
                $display("FAIL start_not_queued cycle=%0d got busy=%b required=0", i, o_busy);
            end
        end
        test_queues_empty("abort_eval");
    endtask

    task automatic test_timeout();
        exp_rden_q.push_back(NS'(1));
        start_window();
        wait_rden();
`ifdef HAAR_SEQ_TIMEOUT_EN
        for (int k = 1; k <= 18; k++) begin
            @(negedge clk_fpga);
            checks++;
            if (o_timeout !== (k == 17) || o_busy !== (k < 17)) begin
                failures++;
                $display("FAIL timeout_k%0d got to=%b busy=%b required to=%b busy=%b",
                         k, o_timeout, o_busy, k == 17, k < 17);
            end
        end
`else
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk_fpga);
            checks++;
            if (o_timeout !== 1'b0 || o_busy !== 1'b1) begin
                failures++;
                $display("FAIL acc_wait_k%0d got to=%b busy=%b required to=0 busy=1", k, o_timeout, o_busy);
            end
        end
        i_abort = 1'b1;
        @(negedge clk_fpga);
        i_abort = 1'b0;
        checks++;
        if (o_busy !== 1'b0) begin
            failures++;
            $display("FAIL abort_acc got busy=%b required=0", o_busy);
        end
`endif
        @(negedge clk_fpga);
        test_queues_empty("timeout");
    endtask

    initial begin
        test_reset();
        test_all_pass();
        test_reset_mid_acc();
        test_saturation();
        test_stage_fail();
        test_back_to_back();
        test_abort_eval();
        test_timeout();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/haar_stage_sequencer.md
# haar_stage_sequencer

Sequences the second-phase Haar cascade for one candidate window. Each stage database is read in turn: the block issues a one-cycle read strobe to the current stage, accumulates the per-classifier weak-learner values, and compares the sum with the stage threshold. It then advances, accepts or rejects. It sits between the first-phase pass signal and the bank of stage databases, and hands a face/no-face verdict to the result collector.

## Interface
Parameters:
- NUM_STAGES, 8, number of second-phase stages; the stage index is 0-based.
- ADDR_WIDTH, 12, width of the classifier counter and the stage index.
- DATA_WIDTH_16, 16, width of the signed weak-learner value and the stage threshold.
- ACC_WIDTH, 20, width of the signed stage accumulator; must be greater than DATA_WIDTH_16.
- TIMEOUT_CYCLES, 1023, watchdog limit; used only with the timeout feature.

Ports:
- clk_fpga  in  1  system clock; all logic is rising-edge.
- reset_fpga  in  1  asynchronous reset, active-high.
- i_start  in  1  a candidate window passed phase one; sampled only in IDLE.
- i_abort  in  1  cancels the current window.
- i_feature_valid  in  1  i_feature_value is valid this cycle.
- i_feature_value  in  DATA_WIDTH_16  signed weak-learner output.
- i_end_count_classifier_index  in  NUM_STAGES  per-stage last-classifier flag from the databases.
- i_stage_threshold  in  DATA_WIDTH_16  signed threshold of the current stage; stable in EVAL.
- o_rden  out  NUM_STAGES  one-hot, single-cycle read strobe to the stage database.
- o_stage_index  out  ADDR_WIDTH  current stage.
- o_classifier_count  out  ADDR_WIDTH  number of values accepted in the current stage.
- o_busy  out  1  high in every state except IDLE.
- o_done  out  1  single-cycle verdict strobe.
- o_face  out  1  verdict; valid when o_done is high and held until the next start.
- o_reject_stage  out  ADDR_WIDTH  stage that rejected the window, or NUM_STAGES on accept.
- o_timeout  out  1  single-cycle watchdog abort strobe.

## Operation
- States: IDLE, REQ, ACC, EVAL, DONE.
- IDLE: when i_start=1:
  - clear the accumulator, o_classifier_count and o_stage_index;
  - go to REQ.
- REQ: drive o_rden = 1 << o_stage_index for exactly one cycle, then go to ACC.
- ACC: on each cycle with i_feature_valid=1:
  - sign-extend the value and add it to the accumulator with saturation at +(2^(ACC_WIDTH-1))-1 / -(2^(ACC_WIDTH-1));
  - increment o_classifier_count; the count saturates at all-ones.
- ACC exit: when i_feature_valid=1 and i_end_count_classifier_index[o_stage_index]=1 in the same cycle, include that value and go to EVAL. An end flag without a valid is ignored.
- EVAL: compare the sign-extended accumulator with the threshold, using the rule accumulator >= threshold.
  - Fail: o_face=0, o_reject_stage=o_stage_index, go to DONE.
  - Pass on the last stage (NUM_STAGES-1): o_face=1, o_reject_stage=NUM_STAGES, go to DONE.
  - Pass otherwise: increment the stage, clear the accumulator and count, go to REQ.
- DONE: o_done=1 for one cycle, then go to IDLE.
- i_abort=1 in any state except IDLE moves the FSM to IDLE on the next edge:
  - no o_done is produced;
  - o_face and o_reject_stage are unchanged;
  - i_abort takes priority over every other transition, including the EVAL and DONE exits.
- i_start is ignored while o_busy=1. It is not queued.

## Timing
- Reset values: state=IDLE, o_rden=0, o_stage_index=0, o_classifier_count=0, o_busy=0, o_done=0, o_face=0, o_reject_stage=0, o_timeout=0, accumulator=0.
- Reset is honoured mid-window immediately and asynchronously.
- All outputs are registered.
- Start to first strobe: i_start is sampled at edge N; o_rden is high during cycle N+1.
- A stage takes 1 (REQ) + K (ACC) + 1 (EVAL) cycles, where K runs to the cycle holding the final valid value.
- Next-stage strobe: appears the cycle after EVAL.
- Verdict: o_done is high the cycle after the deciding EVAL.
- Back-to-back windows: a new i_start is accepted in the cycle after o_done.
- A valid presented in REQ is dropped. The stage database delivers no data earlier than 1 cycle after the strobe.

## Configuration
- HAAR_SEQ_TIMEOUT_EN defined:
  - a watchdog counter runs in ACC;
  - it clears on every i_feature_valid and on every ACC entry;
  - when it reaches TIMEOUT_CYCLES, the block pulses o_timeout for one cycle, goes to IDLE and produces no o_done.
- HAAR_SEQ_TIMEOUT_EN undefined: no counter is built, o_timeout is tied to 0, and ACC waits indefinitely.

## Test plan
- Reset mid-ACC at stage 3 -> all outputs read their reset values during reset; the next i_start yields o_rden=8'b0000_0001.
- All stages pass: each stage delivers 4 values of +10 with threshold 40 -> 8 one-hot strobes in order, then o_done=1, o_face=1, o_reject_stage=8.
- Stage 2 fails: values sum to 39 against threshold 40 -> o_done=1, o_face=0, o_reject_stage=2, and no strobe to stage 3.
- Saturation with ACC_WIDTH=20: 40 values of +32767 -> accumulator=524287, no wrap; threshold 32767 passes.
- i_abort during EVAL of stage 5 -> IDLE next cycle, no o_done; an i_start while busy is ignored.
- With HAAR_SEQ_TIMEOUT_EN defined and TIMEOUT_CYCLES=16: no valids after the strobe -> o_timeout pulses 16 cycles after ACC entry, o_busy falls, o_done stays 0.
